// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type, lane masks and small address helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // IDLE accepts requests; WRITE commits a merged sub-word store.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

    // Alignment rule: halfword needs even address, word needs lane 0,
    // the reserved size encoding is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Bit offset of a little-endian byte lane within the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational lane steering: extracts and extends load data from a
// memory word, and merges right-justified store data into an existing word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted_s;
    logic [31:0] mask_s;
    logic [31:0] ins_s;

    // Load path: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = rd_word >> lane_shift(lane);
        case (size)
            SZ_BYTE: begin
                if (is_unsigned) begin
                    load_data = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (is_unsigned) begin
                    load_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_WORD: load_data = rd_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store path: replace only the target lane(s) of the old word.
    always_comb begin
        case (size)
            SZ_BYTE: begin
                mask_s = BYTE_MASK << lane_shift(lane);
                ins_s  = {24'h00_0000, new_data[7:0]} << lane_shift(lane);
            end
            SZ_HALF: begin
                mask_s = HALF_MASK << lane_shift(lane);
                ins_s  = {16'h0000, new_data[15:0]} << lane_shift(lane);
            end
            SZ_WORD: begin
                mask_s = WORD_MASK;
                ins_s  = new_data;
            end
            default: begin
                mask_s = 32'h0000_0000;
                ins_s  = 32'h0000_0000;
            end
        endcase
        merged_word = (rd_word & ~mask_s) | (ins_s & mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a 256x32 word-addressed data
// memory. Loads and word stores complete in one cycle; byte/halfword stores
// read the old word, merge, and write it back on the following cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_IDX_W = 8,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t  state_r;
    logic [31:0] merge_r;      // merged word awaiting write-back

    logic [1:0]  lane_s;
    logic        misalign_s;
    logic        accept_s;
    logic        load_s;
    logic        word_store_s;
    logic        sub_store_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;
    logic        unused_addr_s;

    // Upper address bits beyond the 1 KiB window are intentionally ignored.
    assign unused_addr_s = ^req_addr[31:WORD_IDX_W+2];

    assign lane_s       = req_addr[1:0];
    assign misalign_s   = req_valid & is_misaligned(req_size, lane_s);
    assign misaligned   = misalign_s;
    assign accept_s     = req_valid & ~misalign_s & (state_r == IDLE);
    assign load_s       = accept_s & ~req_write;
    assign word_store_s = accept_s & req_write & (req_size == SZ_WORD);
    // Only byte/halfword remain once alignment has passed and size is not word.
    assign sub_store_s  = accept_s & req_write & (req_size != SZ_WORD);

    assign mem_address  = {{(32-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};

    lsu_lane_align u_align (
        .rd_word     (mem_read_data),
        .lane        (lane_s),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .new_data    (req_wdata),
        .load_data   (load_data_s),
        .merged_word (merged_s)
    );

    // Sub-word store sequencer: capture the merged word, then write it back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            merge_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sub_store_s) begin
                        merge_r <= merged_s;
                        state_r <= WRITE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Memory-port and core-side muxing; reset blocks any strobe immediately,
    // so a write-back interrupted by reset never reaches the memory.
    always_comb begin
        rdata          = 32'h0000_0000;
        stall          = 1'b0;
        mem_MemRead    = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_write_data = req_wdata;
        if (rst) begin
            mem_MemRead  = 1'b0;
            mem_MemWrite = 1'b0;
        end else if (state_r == WRITE) begin
            mem_MemWrite   = 1'b1;
            mem_write_data = merge_r;
        end else if (load_s) begin
            mem_MemRead = 1'b1;
            rdata       = load_data_s;
        end else if (word_store_s) begin
            mem_MemWrite = 1'b1;
        end else if (sub_store_s) begin
            mem_MemRead = 1'b1;
            stall       = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory-stage control/ALU outputs and the word-addressed data memory (256 x 32, combinational read, write on posedge clk).
- Converts byte addresses into word indices.
- Handles byte, halfword and word accesses with sign or zero extension on loads.
- Implements sub-word stores as a two-cycle read-modify-write, stalling the core during the merge.
- Flags misaligned accesses and suppresses them.

Parameters:
- WORD_IDX_W, 8, width of the word index driven to data memory (256 words).
- DATA_W, 32, data width; fixed at 32, and only 32 is supported.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a memory access this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as misaligned.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- rdata  out  32  extended load result, combinational.
- stall  out  1  core must hold all req_* stable and not advance the PC.
- misaligned  out  1  combinational; the current request is misaligned or has an illegal size.
- mem_address  out  32  word index {zeros, req_addr[WORD_IDX_W+1:2]}.
- mem_write_data  out  32  full word to write.
- mem_MemWrite  out  1  write strobe to data memory.
- mem_MemRead  out  1  read enable to data memory.
- mem_read_data  in  32  word returned by data memory.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state = IDLE, merge_q = 0.
  - Outputs in reset: stall = 0, mem_MemWrite = 0, mem_MemRead = 0.
  - rdata = 0 whenever req_valid = 0.
- Address handling:
  - Byte lane = req_addr[1:0], little-endian (lane 0 = bits 7:0).
  - req_addr[31:WORD_IDX_W+2] are ignored, so addresses wrap modulo 1 KiB.
- Alignment:
  - A halfword access needs addr[0] = 0.
  - A word access needs addr[1:0] = 0.
  - size 11 is always misaligned.
  - When misaligned=1: mem_MemRead = 0, mem_MemWrite = 0, stall = 0, rdata = 0, no state change.
- Loads (valid, !write, aligned):
  - Single cycle with no stall: mem_MemRead = 1, and rdata is the selected lane extended per req_unsigned.
  - Word loads ignore req_unsigned.
- Word store (aligned):
  - Single cycle: mem_MemWrite = 1 and mem_write_data = req_wdata.
  - Stall = 0 and the FSM stays in IDLE.
- Sub-word store FSM, two states:
  - IDLE: on a valid aligned byte/halfword store, assert mem_MemRead = 1 and stall = 1.
    - Latch the merged word into merge_q: mem_read_data with the target lane(s) replaced by req_wdata[7:0] or [15:0].
    - Go to WRITE.
  - WRITE: mem_MemWrite = 1, mem_write_data = merge_q, mem_MemRead = 0, stall = 0. Return to IDLE unconditionally.
  - Request inputs are ignored in WRITE except req_addr, which drives mem_address. The core holds req_addr because stall was high in the prior cycle.
- Simultaneous events:
  - A new request can be accepted in the cycle after WRITE.
  - No back-to-back hazard exists, because memory reads are combinational of the committed array.
- Reset mid-operation:
  - rst asserted while in WRITE forces mem_MemWrite = 0 combinationally in that cycle, so the memory is unchanged.
  - The FSM returns to IDLE.
  - rst has priority over every request.
- mem_MemWrite is never high in the same cycle as mem_MemRead.

Decomposition:
- Shared package (lsu_pkg):
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum (IDLE, WRITE).
  - lane-mask constants.
- One natural sub-module: lsu_lane_align. It is purely combinational and produces:
  - load extract/extend from (word, lane, size, unsigned);
  - store merge (old word, new data, lane, size).
- The FSM, alignment check and memory-port muxing stay in load_store_unit.

Test Plan:
- Preload memory word1 = 1, word2 = 1001 (0x000003E9).
- LB at addr 8, signed -> rdata = 0xFFFFFFE9, stall = 0, mem_address = 2, mem_MemRead = 1.
- LBU at addr 8 -> 0x000000E9. LH at addr 8 -> 0x000003E9. LB at addr 9 -> 0x00000003.
- SB 0xAA at addr 5 -> cycle 0: stall = 1, mem_MemRead = 1. Cycle 1: mem_MemWrite = 1, data 0x0000AA01. A subsequent LW at addr 4 -> 0x0000AA01.
- SH 0xBEEF at addr 10 -> word2 = 0xBEEF03E9 after 2 cycles. SW 0x12345678 at addr 12 -> written in 1 cycle with no stall.
- LW at addr 6, SH at addr 3, size 11 at addr 0 -> misaligned = 1, no MemRead/MemWrite, memory unchanged.
- SB 0x55 at addr 4 with rst asserted during the WRITE cycle -> mem_MemWrite = 0 that cycle, word1 unchanged, state IDLE, stall = 0 the next cycle.
